// File: rtl/spi_master_pkg.sv
// Shared constants for the APB SPI master: register offsets, CTRL/STATUS bit
// positions and the shift-engine state encoding.
package spi_master_pkg;

    localparam logic [11:0] REG_CTRL   = 12'h000;
    localparam logic [11:0] REG_CLKDIV = 12'h004;
    localparam logic [11:0] REG_LEN    = 12'h008;
    localparam logic [11:0] REG_TXDATA = 12'h00C;
    localparam logic [11:0] REG_RXDATA = 12'h010;
    localparam logic [11:0] REG_STATUS = 12'h014;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_OVF_CLR_BIT = 1;

    localparam int ST_BUSY_BIT     = 0;
    localparam int ST_TX_FULL_BIT  = 1;
    localparam int ST_TX_EMPTY_BIT = 2;
    localparam int ST_RX_EMPTY_BIT = 3;
    localparam int ST_OVF_BIT      = 4;
    localparam int ST_RX_LVL_LSB   = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LOW  = 3'd2,
        ST_HIGH = 3'd3,
        ST_DONE = 3'd4
    } spi_state_e;

    // LEN field value 0 encodes a full 32-bit word.
    function automatic logic [5:0] word_bits(input logic [4:0] len);
        return (len == 5'd0) ? 6'd32 : {1'b0, len};
    endfunction

endpackage

// File: rtl/spi_master_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is readable combinationally.
module spi_master_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is refused even when a pop happens the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/apb_spi_master_lite.sv
// Mode-0, MSB-first SPI master with TX/RX FIFOs behind an APB slave register
// file; raises RX-word and queue-drained event pulses.
module apb_spi_master_lite
    import spi_master_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      spi_clk_o,
    output logic                      spi_csn_o,
    output logic                      spi_sdo_o,
    input  logic                      spi_sdi_i,
    output logic [1:0]                events_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // Handshake: APB access completes in the cycle PSEL & PENABLE are high
    // (PREADY is tied 1); PSLVERR qualifies that same cycle and an erroring
    // access changes no state.

    logic        en;
    logic        ovf;
    logic [7:0]  clkdiv;
    logic [4:0]  len;

    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [31:0] tx_head;
    logic [LW-1:0] tx_level;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [31:0] rx_head;
    logic [LW-1:0] rx_level;

    spi_state_e  state, state_n;
    logic [7:0]  div_cnt;
    logic [7:0]  d_lat;
    logic [5:0]  bit_cnt;
    logic [31:0] tx_shreg;
    logic [31:0] rx_shreg;
    logic        ev_drain;

    logic        apb_access, apb_wr, apb_rd;
    logic [31:0] prdata_c;
    logic        err_c;
    logic [31:0] status;
    logic [5:0]  n_cfg;
    logic [31:0] load_word;
    logic        div_end;

    spi_master_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (PWDATA),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    spi_master_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shreg),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign apb_access = PSEL && PENABLE;
    assign apb_wr     = apb_access && PWRITE;
    assign apb_rd     = apb_access && !PWRITE;

    always_comb begin
        status = '0;
        status[ST_BUSY_BIT]     = (state != ST_IDLE);
        status[ST_TX_FULL_BIT]  = tx_full;
        status[ST_TX_EMPTY_BIT] = tx_empty;
        status[ST_RX_EMPTY_BIT] = rx_empty;
        status[ST_OVF_BIT]      = ovf;
        status = status | (32'(rx_level) << ST_RX_LVL_LSB);
    end

    // Read mux and error decode; the write-only TXDATA reads back as zero.
    always_comb begin
        prdata_c = '0;
        err_c    = 1'b0;
        case (PADDR)
            APB_ADDR_WIDTH'(REG_CTRL):   prdata_c = {31'b0, en};
            APB_ADDR_WIDTH'(REG_CLKDIV): prdata_c = {24'b0, clkdiv};
            APB_ADDR_WIDTH'(REG_LEN):    prdata_c = {27'b0, len};
            APB_ADDR_WIDTH'(REG_TXDATA): err_c = PWRITE && tx_full;
            APB_ADDR_WIDTH'(REG_RXDATA): begin
                err_c    = PWRITE || rx_empty;
                prdata_c = rx_empty ? 32'h0 : rx_head;
            end
            APB_ADDR_WIDTH'(REG_STATUS): begin
                err_c    = PWRITE;
                prdata_c = status;
            end
            default: err_c = 1'b1;
        endcase
    end

    assign PRDATA  = PSEL ? prdata_c : 32'h0;
    assign PREADY  = 1'b1;
    assign PSLVERR = apb_access && err_c;

    assign tx_push = apb_wr && (PADDR == APB_ADDR_WIDTH'(REG_TXDATA)) && !tx_full;
    assign rx_pop  = apb_rd && (PADDR == APB_ADDR_WIDTH'(REG_RXDATA)) && !rx_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            en     <= 1'b0;
            clkdiv <= 8'h00;
            len    <= 5'h00;
        end else if (apb_wr) begin
            if (PADDR == APB_ADDR_WIDTH'(REG_CTRL))   en     <= PWDATA[CTRL_EN_BIT];
            if (PADDR == APB_ADDR_WIDTH'(REG_CLKDIV)) clkdiv <= PWDATA[7:0];
            if (PADDR == APB_ADDR_WIDTH'(REG_LEN))    len    <= PWDATA[4:0];
        end
    end

    // Word is left-justified so the engine always shifts out of bit 31.
    assign n_cfg     = word_bits(len);
    assign load_word = tx_head << (6'd32 - n_cfg);
    assign div_end   = (div_cnt == d_lat);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state)
            ST_IDLE: if (en && !tx_empty) state_n = ST_LOAD;
            ST_LOAD: begin
                tx_pop  = 1'b1;
                state_n = ST_LOW;
            end
            ST_LOW:  if (div_end) state_n = ST_HIGH;
            ST_HIGH: if (div_end) state_n = (bit_cnt == 6'd1) ? ST_DONE : ST_LOW;
            ST_DONE: begin
                rx_push = 1'b1;
                state_n = (en && !tx_empty) ? ST_LOAD : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= 8'h00;
            d_lat    <= 8'h00;
            bit_cnt  <= 6'd0;
            tx_shreg <= 32'h0;
            rx_shreg <= 32'h0;
            ovf      <= 1'b0;
            ev_drain <= 1'b0;
        end else begin
            if ((state == ST_LOW || state == ST_HIGH) && state_n == state)
                div_cnt <= div_cnt + 8'd1;
            else
                div_cnt <= 8'h00;

            if (state == ST_LOAD) begin
                tx_shreg <= load_word;
                bit_cnt  <= n_cfg;
                d_lat    <= clkdiv;
                rx_shreg <= 32'h0;
            end

            // MISO is captured on the first cycle of the high phase.
            if (state == ST_HIGH) begin
                if (div_cnt == 8'h00) rx_shreg <= {rx_shreg[30:0], spi_sdi_i};
                if (div_end) begin
                    bit_cnt <= bit_cnt - 6'd1;
                    if (bit_cnt != 6'd1) tx_shreg <= tx_shreg << 1;
                end
            end

            if (apb_wr && PADDR == APB_ADDR_WIDTH'(REG_CTRL) && PWDATA[CTRL_OVF_CLR_BIT])
                ovf <= 1'b0;
            if (state == ST_DONE && rx_full)
                ovf <= 1'b1;

            ev_drain <= (state == ST_DONE) && (state_n == ST_IDLE);
        end
    end

    always_comb begin
        case (state)
            ST_IDLE: spi_sdo_o = 1'b0;
            ST_LOAD: spi_sdo_o = load_word[31];
            default: spi_sdo_o = tx_shreg[31];
        endcase
    end

    assign spi_csn_o   = (state == ST_IDLE);
    assign spi_clk_o   = (state == ST_HIGH);
    assign events_o[0] = (state == ST_DONE) && !rx_full;
    assign events_o[1] = ev_drain;

endmodule

// File: doc/apb_spi_master_lite.md
Name: apb_spi_master_lite

Overview:
- Single-lane SPI master (mode 0, MSB first) with an APB slave register interface.
- Sits in the APB peripheral slot 2, restoring the SPI-master path; it is the initiator counterpart to the SPI-slave/AXI-master block.
- Software pushes words into a TX FIFO. The engine shifts each word out on spi_sdo_o while capturing spi_sdi_i into an RX FIFO.
- Raises event pulses for the event unit (s_spim_event[1:0]).

Parameters:
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs (power of 2, ≥2)
APB_ADDR_WIDTH, 12, APB address bits used

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  synchronous, active-high reset
PADDR  in  12  APB address (word-aligned)
PWDATA  in  32  APB write data
PWRITE  in  1  APB write strobe
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PRDATA  out  32  APB read data
PREADY  out  1  always 1
PSLVERR  out  1  access error, valid in the access phase
spi_clk_o  out  1  SCLK, idle low
spi_csn_o  out  1  chip select, active low
spi_sdo_o  out  1  MOSI
spi_sdi_i  in  1  MISO
events_o  out  2  [0] RX word pushed pulse, [1] queue drained pulse

Behaviour:
- Interface decisions: one clock, clk; reset rst is synchronous and active-high. The APB access completes in the cycle where PSEL&PENABLE is high, with no wait states.
- Register map:
  - 0x00 CTRL (rw): [0] EN; [1] write-1 clears OVF (reads 0).
  - 0x04 CLKDIV (rw): [7:0] d. Each SCLK half-period lasts d+1 clk cycles.
  - 0x08 LEN (rw): [4:0] bits per word N; value 0 means 32.
  - 0x0C TXDATA (wo): push to the TX FIFO.
  - 0x10 RXDATA (ro): pop from the RX FIFO. Data is right-aligned and zero-extended.
  - 0x14 STATUS (ro): [0] busy, [1] tx_full, [2] tx_empty, [3] rx_empty, [4] OVF, [10:8] rx level.
- PSLVERR=1 in these cases, and the access has no side effect:
  - write to TXDATA when the TX FIFO is full;
  - read of RXDATA when the RX FIFO is empty;
  - any unmapped offset, or a write to a read-only offset.
- PRDATA is combinational from the selected register and 0 when not selected.
- Reset values: CTRL=0, CLKDIV=0, LEN=0, both FIFOs empty, OVF=0, spi_csn_o=1, spi_clk_o=0, spi_sdo_o=0, events_o=0, FSM=IDLE.
- Reset mid-transfer aborts immediately. spi_csn_o=1 on the cycle after rst is sampled, and the partial RX word is discarded.
- FSM states: IDLE, LOAD, LOW, HIGH, DONE.
  - IDLE: csn=1, sclk=0. If EN & !tx_empty, go to LOAD.
  - LOAD (1 cycle):
    - pop TX; latch N and d (later CLKDIV/LEN writes apply at the next LOAD);
    - shreg = data << (32-N); bitcnt = N;
    - csn=0; sdo=MSB; go to LOW.
  - LOW: sclk=0 for d+1 cycles, then go to HIGH.
  - HIGH:
    - on entry, sclk=1 and sdi is sampled into the RX shift register (LSB in);
    - held for d+1 cycles, then bitcnt decrements;
    - if bitcnt≠0: shift shreg left, update sdo, go to LOW; otherwise go to DONE.
  - DONE (1 cycle):
    - sclk=0; push the RX word and pulse events_o[0].
    - If the RX FIFO is full, the word is dropped, OVF=1 (sticky), and no events_o[0] pulse is issued.
    - If EN & !tx_empty, go to LOAD with csn held low (back-to-back words).
    - Otherwise go to IDLE with csn=1 and pulse events_o[1].
- Word cost is 2 + 2·N·(d+1) cycles.
- busy = (state≠IDLE).
- Clearing EN mid-word lets the current word complete; the FSM then returns to IDLE.
- An APB push and an engine pop in the same cycle are both honoured (FIFO level unchanged). A push into a full FIFO is refused even if a pop happens that cycle. The same rule applies to RX pop and engine push.
- FIFO pointers carry one extra wrap bit: full = MSBs differ and the rest are equal; empty = all bits equal.

Decomposition:
- spi_master_pkg holds:
  - register offset localparams;
  - the STATUS/CTRL bit-position constants;
  - the FSM state enum (typedef logic [2:0]).
- Sub-module spi_master_fifo (WIDTH, DEPTH) is instantiated twice, for TX and RX. Its signals are push/pop/full/empty/level. Read data is combinational from the head entry.

Test Plan:
- Reset with FIFOs pre-filled → STATUS = 0x0000_000C, csn=1, sclk=0, PRDATA=0; FIFO contents lost.
- d=0, N=8, EN=1, TX=0xA5, sdi looped to sdo → exactly 8 SCLK rising edges, sdo sequence 1,0,1,0,0,1,0,1, csn low for 18 cycles, RXDATA=0x0000_00A5, events_o[0] then events_o[1] each 1-cycle pulse.
- d=2, N=0 (32 bits), TX=0xDEADBEEF, sdi tied 1 → SCLK high/low phases of 3 cycles each, RX=0xFFFF_FFFF, 194 cycles LOAD→DONE.
- Push 5 words with depth 4 and EN=0 → 5th write returns PSLVERR=1, STATUS.tx_full=1; set EN → 4 back-to-back words, csn never deasserted between words.
- 5 words transferred without reading RX → OVF=1 after the 5th, RX level=4; CTRL write 0x2 → OVF=0; reading 5 times → 5th read gives PSLVERR=1.
- Assert rst during bit 3 of a word → next cycle csn=1, sclk=0, busy=0, RX empty, no event pulse.
